// File: rtl/cpu_pkg.sv
// Shared constants for the accumulator/execute slice: default widths,
// operation codes and the sequencer state encodings.
package cpu_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_CNT_W = 16;

   localparam logic [1:0] OP_LDA = 2'b00;
   localparam logic [1:0] OP_ADD = 2'b01;
   localparam logic [1:0] OP_CLR = 2'b10;
   localparam logic [1:0] OP_NOP = 2'b11;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_EXEC = 2'b01;
   localparam logic [1:0] ST_RESP = 2'b10;

endpackage

// File: rtl/adder.sv
// Plain WIDTH-bit adder; the sum wraps modulo 2^WIDTH and there is no carry-out port.
module adder #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum
);

   assign sum = a + b;

endmodule

// File: rtl/acc_exec_unit.sv
// Accumulator and execute sequencer: takes one operation, runs it through the
// adder, and hands the new accumulator value downstream with carry/zero flags.
module acc_exec_unit
   import cpu_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [1:0]       op_code,
   input  logic [WIDTH-1:0] operand,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             flag_c,
   output logic             flag_z,
   output logic [CNT_W-1:0] op_count,
   output logic [1:0]       dbg_state
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [1:0]       state;
   logic [1:0]       code_q;
   logic [WIDTH-1:0] opnd_q;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] acc_next;
   logic             c_next;

   adder #(.WIDTH(WIDTH)) u_adder (
      .a   (acc_q),
      .b   (opnd_q),
      .sum (sum)
   );

   // Handshakes: a transfer happens on a rising edge where valid and ready are both
   // high; the sender holds valid and payload steady until that edge.
   assign op_ready  = rst_n && (state == ST_IDLE);
   assign res_data  = acc_q;
   assign dbg_state = state;

   always_comb begin
      acc_next = acc_q;
      c_next   = flag_c;
      case (code_q)
         OP_ADD: begin
            acc_next = sum;
            c_next   = (sum < acc_q);
         end
         OP_LDA: begin
            acc_next = opnd_q;
            c_next   = 1'b0;
         end
         OP_CLR: begin
            acc_next = '0;
            c_next   = 1'b0;
         end
         default: begin
            acc_next = acc_q;
            c_next   = flag_c;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         code_q    <= OP_LDA;
         opnd_q    <= '0;
         acc_q     <= '0;
         flag_c    <= 1'b0;
         flag_z    <= 1'b0;
         res_valid <= 1'b0;
         op_count  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (op_valid) begin
                  code_q <= op_code;
                  opnd_q <= operand;
                  state  <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               acc_q     <= acc_next;
               flag_c    <= c_next;
               flag_z    <= (acc_next == '0);
               res_valid <= 1'b1;
               state     <= ST_RESP;
            end
            ST_RESP: begin
               // Result and flags hold until the consumer takes them; no bypass to a new accept.
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state     <= ST_IDLE;
                  if (op_count != CNT_MAX) op_count <= op_count + CNT_ONE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_acc_exec_unit.sv
// Bench for acc_exec_unit: directed table, backpressure and reset sequences, and
// random operations checked against an arithmetic model of the accumulator.
module tb_acc_exec_unit;

   localparam int WIDTH = 8;
   localparam int CNT_W = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   localparam logic [1:0] C_LDA = 2'b00;
   localparam logic [1:0] C_ADD = 2'b01;
   localparam logic [1:0] C_CLR = 2'b10;
   localparam logic [1:0] C_NOP = 2'b11;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             op_valid = 1'b0;
   logic             op_ready;
   logic [1:0]       op_code = 2'b00;
   logic [WIDTH-1:0] operand = '0;
   logic             res_valid;
   logic             res_ready = 1'b0;
   logic [WIDTH-1:0] res_data;
   logic             flag_c;
   logic             flag_z;
   logic [CNT_W-1:0] op_count;
   logic [1:0]       dbg_state;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state
   int m_acc = 0;
   int m_c = 0;
   int m_z = 0;
   int m_cnt = 0;

   acc_exec_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .op_valid  (op_valid),
      .op_ready  (op_ready),
      .op_code   (op_code),
      .operand   (operand),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .flag_c    (flag_c),
      .flag_z    (flag_z),
      .op_count  (op_count),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_acc = 0; m_c = 0; m_z = 0; m_cnt = 0;
   endtask

   task automatic model_op(input logic [1:0] code, input int opnd);
      int s;
      case (code)
         C_ADD: begin
            s = m_acc + opnd;
            m_c = (s >= 256) ? 1 : 0;
            m_acc = s % 256;
         end
         C_LDA: begin m_acc = opnd; m_c = 0; end
         C_CLR: begin m_acc = 0; m_c = 0; end
         default: ;
      endcase
      m_z = (m_acc == 0) ? 1 : 0;
   endtask

   // Offer an op, wait (bounded) for acceptance, then check EXEC and RESP timing and values.
   task automatic issue_op(input logic [1:0] code, input logic [7:0] opnd);
      int waited;
      @(negedge clk);
      op_valid = 1'b1; op_code = code; operand = opnd;
      waited = 0;
      while (!op_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      chk("accept_ready", {31'd0, op_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      op_valid = 1'b0;
      op_code = 2'($urandom);
      operand = 8'($urandom);
      chk("exec_res_valid", {31'd0, res_valid}, 32'd0);
      chk("exec_op_ready", {31'd0, op_ready}, 32'd0);
      @(negedge clk);
      model_op(code, int'(opnd));
      chk("resp_res_valid", {31'd0, res_valid}, 32'd1);
      chk("resp_data", {24'd0, res_data}, m_acc);
      chk("resp_flag_c", {31'd0, flag_c}, m_c);
      chk("resp_flag_z", {31'd0, flag_z}, m_z);
      chk("resp_count", {28'd0, op_count}, m_cnt);
   endtask

   // Hold the result for 'stall' cycles with a competing op offered, then complete the handshake.
   task automatic finish_op(input int stall);
      for (int i = 0; i < stall; i++) begin
         op_valid = 1'b1;
         op_code = 2'($urandom);
         operand = 8'($urandom);
         @(negedge clk);
         chk("stall_res_valid", {31'd0, res_valid}, 32'd1);
         chk("stall_data", {24'd0, res_data}, m_acc);
         chk("stall_flags", {30'd0, flag_c, flag_z}, (m_c << 1) | m_z);
         chk("stall_op_ready", {31'd0, op_ready}, 32'd0);
         chk("stall_count", {28'd0, op_count}, m_cnt);
      end
      op_valid = 1'b0;
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      if (m_cnt < CNT_MAX) m_cnt++;
      chk("done_count", {28'd0, op_count}, m_cnt);
      chk("done_res_valid", {31'd0, res_valid}, 32'd0);
      chk("done_op_ready", {31'd0, op_ready}, 32'd1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      model_reset();
      chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
      chk("rst_data", {24'd0, res_data}, 32'd0);
      chk("rst_flags", {30'd0, flag_c, flag_z}, 32'd0);
      chk("rst_count", {28'd0, op_count}, 32'd0);
      chk("rst_op_ready", {31'd0, op_ready}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_op_ready", {31'd0, op_ready}, 32'd1);
   endtask

   typedef struct {
      logic [1:0] code;
      logic [7:0] opnd;
      int         stall;
      logic [7:0] exp_data;
      logic       exp_c;
      logic       exp_z;
   } vec_t;

   vec_t tbl[10];

   initial begin
      tbl[0] = '{C_LDA, 8'hAA, 0, 8'hAA, 1'b0, 1'b0};
      tbl[1] = '{C_ADD, 8'h55, 0, 8'hFF, 1'b0, 1'b0};
      tbl[2] = '{C_LDA, 8'hFF, 0, 8'hFF, 1'b0, 1'b0};
      tbl[3] = '{C_ADD, 8'h01, 0, 8'h00, 1'b1, 1'b1};
      tbl[4] = '{C_LDA, 8'hFF, 0, 8'hFF, 1'b0, 1'b0};
      tbl[5] = '{C_ADD, 8'h7F, 5, 8'h7E, 1'b1, 1'b0};
      tbl[6] = '{C_NOP, 8'h33, 0, 8'h7E, 1'b1, 1'b0};
      tbl[7] = '{C_CLR, 8'h12, 0, 8'h00, 1'b0, 1'b1};
      tbl[8] = '{C_LDA, 8'h80, 0, 8'h80, 1'b0, 1'b0};
      tbl[9] = '{C_ADD, 8'h80, 3, 8'h00, 1'b1, 1'b1};

      repeat (3) @(posedge clk);
      do_reset();

      // Reset landing mid-RESP discards the pending result.
      issue_op(C_LDA, 8'h5A);
      do_reset();

      for (int i = 0; i < 10; i++) begin
         issue_op(tbl[i].code, tbl[i].opnd);
         chk("tbl_data", {24'd0, res_data}, {24'd0, tbl[i].exp_data});
         chk("tbl_flag_c", {31'd0, flag_c}, {31'd0, tbl[i].exp_c});
         chk("tbl_flag_z", {31'd0, flag_z}, {31'd0, tbl[i].exp_z});
         finish_op(tbl[i].stall);
      end

      for (int i = 0; i < 40; i++) begin
         issue_op(2'($urandom_range(0, 3)), 8'($urandom));
         finish_op($urandom_range(0, 2));
      end

      // The counter has seen far more ops than it can hold: it must be pinned at all-ones.
      chk("count_saturated", {28'd0, op_count}, CNT_MAX);
      issue_op(C_NOP, 8'h00);
      finish_op(0);
      chk("count_still_sat", {28'd0, op_count}, CNT_MAX);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
